// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU.
// Holds the opcode encodings, the control FSM state type and a helper that
// decides whether an operation runs on the iterative mul/div datapath.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_MUL   = 4'd2;
  localparam logic [3:0] ALU_DIV   = 4'd3;
  localparam logic [3:0] ALU_INC   = 4'd4;
  localparam logic [3:0] ALU_DEC   = 4'd5;
  localparam logic [3:0] ALU_PASSA = 4'd6;
  localparam logic [3:0] ALU_PASSB = 4'd7;
  localparam logic [3:0] ALU_AND   = 4'd8;
  localparam logic [3:0] ALU_OR    = 4'd9;
  localparam logic [3:0] ALU_XOR   = 4'd10;
  localparam logic [3:0] ALU_NOT   = 4'd11;
  localparam logic [3:0] ALU_SHL   = 4'd12;
  localparam logic [3:0] ALU_SHR   = 4'd13;
  localparam logic [3:0] ALU_NAND  = 4'd14;
  localparam logic [3:0] ALU_NOR   = 4'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  // Division by zero short-circuits to a one-cycle all-ones result, so only a
  // non-zero divisor needs the iterative datapath.
  function automatic logic needs_iter(input logic [3:0] op, input logic b_zero,
                                      input logic fast_mul);
    return ((op == ALU_DIV) && !b_zero) || ((op == ALU_MUL) && !fast_mul);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// Runs exactly WIDTH iterations after start_i.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : load operands (a_i, b_i) and mode (is_div_i)
//   done_o     : high during the cycle whose closing edge performs the last iteration
//   result_o   : mul -> full product; div -> {remainder, quotient}
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic             is_div_q, is_div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // hi: running partial product / remainder; lo: multiplier / dividend-quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand or divisor

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;

  always_comb begin
    busy_d   = busy_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};

    if (start_i) begin
      busy_d   = 1'b1;
      is_div_d = is_div_i;
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = is_div_i ? a_i : b_i;
      opnd_d   = is_div_i ? b_i : a_i;
    end else if (busy_q) begin
      if (is_div_q) begin
        // Restore (keep the shifted value) when the trial subtraction underflows.
        if (div_trial[WIDTH]) begin
          hi_d = div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end else begin
          hi_d = div_trial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
    end
  end

  assign done_o   = busy_q && (cnt_q == LastCnt);
  assign result_o = {hi_q, lo_q};

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with an IDLE/CALC/DONE handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_i / ready_o : request accepted when both high
//   a_i, b_i, opcode_i: operands and operation, latched on accept
//   out_alu_o         : 2*WIDTH registered result, held until the next done
//   done_o            : one-cycle pulse when result and flags update
//   *_flag_o          : unsigned compare flags of the latched operands
//   div_by_zero_o     : set with done for div by 0, cleared on next accept
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FAST_MUL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [3:0]         opcode_i,
  output logic [2*WIDTH-1:0] out_alu_o,
  output logic               done_o,
  output logic               z_a_flag_o,
  output logic               z_b_flag_o,
  output logic               a_bigger_flag_o,
  output logic               b_bigger_flag_o,
  output logic               eq_flag_o,
  output logic               div_by_zero_o
);

  localparam int unsigned W2 = 2 * WIDTH;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             is_iter_q;
  logic [W2-1:0]    out_alu_q;
  logic             done_q;
  logic [4:0]       flags_q;  // {z_a, z_b, a_bigger, b_bigger, eq}
  logic             dbz_q;

  logic             accept;
  logic             iter_req;
  logic             iter_start;
  logic             iter_done;
  logic [W2-1:0]    iter_res;
  logic [W2-1:0]    comb_res;
  logic [W2-1:0]    result;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;

  assign accept     = (state_q == StIdle) && start_i;
  assign iter_req   = needs_iter(opcode_i, (b_i == '0), (FAST_MUL != 0));
  assign iter_start = accept && iter_req;

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (iter_start),
    .is_div_i (opcode_i == ALU_DIV),
    .a_i      (a_i),
    .b_i      (b_i),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

  // Single-cycle operations, evaluated on the latched operands while in DONE.
  always_comb begin
    comb_res = '0;
    sum_w    = {1'b0, a_q} + {1'b0, b_q};
    // Top bit of the widened difference is the borrow (a < b).
    diff_w   = {1'b0, a_q} - {1'b0, b_q};
    unique case (op_q)
      ALU_ADD:   comb_res = {{(WIDTH-1){1'b0}}, sum_w};
      ALU_SUB:   comb_res = {{(WIDTH-1){1'b0}}, diff_w};
      ALU_MUL:   comb_res = (FAST_MUL != 0) ? (W2'(a_q) * W2'(b_q)) : '0;
      ALU_DIV:   comb_res = '1;  // only reached with b == 0
      ALU_INC:   comb_res = {{WIDTH{1'b0}}, a_q + 1'b1};
      ALU_DEC:   comb_res = {{WIDTH{1'b0}}, a_q - 1'b1};
      ALU_PASSA: comb_res = {{WIDTH{1'b0}}, a_q};
      ALU_PASSB: comb_res = {{WIDTH{1'b0}}, b_q};
      ALU_AND:   comb_res = {{WIDTH{1'b0}}, a_q & b_q};
      ALU_OR:    comb_res = {{WIDTH{1'b0}}, a_q | b_q};
      ALU_XOR:   comb_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      ALU_NOT:   comb_res = {{WIDTH{1'b0}}, ~a_q};
      ALU_SHL:   comb_res = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], 1'b0};
      ALU_SHR:   comb_res = {{WIDTH{1'b0}}, 1'b0, a_q[WIDTH-1:1]};
      ALU_NAND:  comb_res = {{WIDTH{1'b0}}, ~(a_q & b_q)};
      ALU_NOR:   comb_res = {{WIDTH{1'b0}}, ~(a_q | b_q)};
      default:   comb_res = '0;
    endcase
    result = is_iter_q ? iter_res : comb_res;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = iter_req ? StCalc : StDone;
        end
      end
      StCalc: begin
        if (iter_done) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= ALU_ADD;
      is_iter_q <= 1'b0;
      out_alu_q <= '0;
      done_q    <= 1'b0;
      flags_q   <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StDone);
      if (accept) begin
        a_q       <= a_i;
        b_q       <= b_i;
        op_q      <= opcode_i;
        is_iter_q <= iter_req;
        dbz_q     <= 1'b0;
      end
      if (state_q == StDone) begin
        out_alu_q <= result;
        flags_q   <= {a_q == '0, b_q == '0, a_q > b_q, b_q > a_q, a_q == b_q};
        dbz_q     <= (op_q == ALU_DIV) && (b_q == '0);
      end
    end
  end

  assign ready_o         = (state_q == StIdle);
  assign out_alu_o       = out_alu_q;
  assign done_o          = done_q;
  assign z_a_flag_o      = flags_q[4];
  assign z_b_flag_o      = flags_q[3];
  assign a_bigger_flag_o = flags_q[2];
  assign b_bigger_flag_o = flags_q[1];
  assign eq_flag_o       = flags_q[0];
  assign div_by_zero_o   = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=16, FAST_MUL=0): directed and
// random operations compared against an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        ready_o;
  logic [15:0] a_i, b_i;
  logic [3:0]  opcode_i;
  logic [31:0] out_alu_o;
  logic        done_o;
  logic        z_a_flag_o, z_b_flag_o, a_bigger_flag_o, b_bigger_flag_o, eq_flag_o;
  logic        div_by_zero_o;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] last_exp = '0;

  alu_multicycle #(
    .WIDTH    (16),
    .FAST_MUL (0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .ready_o         (ready_o),
    .a_i             (a_i),
    .b_i             (b_i),
    .opcode_i        (opcode_i),
    .out_alu_o       (out_alu_o),
    .done_o          (done_o),
    .z_a_flag_o      (z_a_flag_o),
    .z_b_flag_o      (z_b_flag_o),
    .a_bigger_flag_o (a_bigger_flag_o),
    .b_bigger_flag_o (b_bigger_flag_o),
    .eq_flag_o       (eq_flag_o),
    .div_by_zero_o   (div_by_zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model written with plain 32-bit unsigned arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int unsigned ua, ub;
    ua = 32'(a);
    ub = 32'(b);
    case (op)
      4'd0:  return ua + ub;
      4'd1:  return ((ua - ub) & 32'hFFFF) | ((ua < ub) ? 32'h1_0000 : 32'h0);
      4'd2:  return ua * ub;
      4'd3:  return (ub == 0) ? 32'hFFFF_FFFF : (((ua % ub) << 16) | (ua / ub));
      4'd4:  return (ua + 1) & 32'hFFFF;
      4'd5:  return (ua - 1) & 32'hFFFF;
      4'd6:  return ua;
      4'd7:  return ub;
      4'd8:  return ua & ub;
      4'd9:  return ua | ub;
      4'd10: return ua ^ ub;
      4'd11: return (~ua) & 32'hFFFF;
      4'd12: return (ua << 1) & 32'hFFFF;
      4'd13: return ua >> 1;
      4'd14: return (~(ua & ub)) & 32'hFFFF;
      default: return (~(ua | ub)) & 32'hFFFF;
    endcase
  endfunction

  function automatic logic [4:0] flags_now();
    return {z_a_flag_o, z_b_flag_o, a_bigger_flag_o, b_bigger_flag_o, eq_flag_o};
  endfunction

  // Issue one operation; optionally pulse start again while busy.
  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit poke);
    logic [31:0] exp;
    logic [4:0]  ef;
    int          lat, n, busy, extra;
    bit          got;
    string       t;
    exp = model(op, a, b);
    lat = (op == 4'd2 || (op == 4'd3 && b != 16'd0)) ? 17 : 1;
    ef  = {a == 16'd0, b == 16'd0, a > b, b > a, a == b};
    t   = $sformatf("op%0d a=%0h b=%0h", op, a, b);

    n = 0;
    while (!ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    start_i = 1'b1; a_i = a; b_i = b; opcode_i = op;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = 16'($urandom); b_i = 16'($urandom); opcode_i = 4'($urandom);
    chk({t, " ready_after_accept"}, 64'(ready_o), 64'd0);
    chk({t, " dbz_cleared"}, 64'(div_by_zero_o), 64'd0);
    chk({t, " out_held"}, 64'(out_alu_o), 64'(last_exp));

    n = 0; busy = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (done_o) begin
        got = 1'b1;
      end else begin
        if (!ready_o) busy++;
        if (poke) begin
          start_i = (n == 5);
          if (n == 5) begin
            opcode_i = 4'd0; a_i = 16'd1; b_i = 16'd1;
          end
        end
      end
    end
    start_i = 1'b0;
    chk({t, " done_seen"}, 64'(got), 64'd1);
    chk({t, " latency"}, 64'(n), 64'(lat));
    chk({t, " ready_low_cycles"}, 64'(busy), 64'(lat - 1));
    chk({t, " out_alu"}, 64'(out_alu_o), 64'(exp));
    chk({t, " flags"}, 64'(flags_now()), 64'(ef));
    chk({t, " dbz"}, 64'(div_by_zero_o), 64'(op == 4'd3 && b == 16'd0));
    last_exp = exp;

    @(posedge clk); #1;
    chk({t, " done_pulse"}, 64'(done_o), 64'd0);
    if (poke) begin
      extra = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (done_o) extra++;
      end
      chk({t, " extra_done"}, 64'(extra), 64'd0);
      chk({t, " out_after_poke"}, 64'(out_alu_o), 64'(exp));
    end
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; opcode_i = '0;
    #1;
    chk("rst ready", 64'(ready_o), 64'd1);
    chk("rst done", 64'(done_o), 64'd0);
    chk("rst out_alu", 64'(out_alu_o), 64'd0);
    chk("rst flags", 64'(flags_now()), 64'd0);
    chk("rst dbz", 64'(div_by_zero_o), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_op(4'd0, 16'h0004, 16'h0001, 1'b0);
    do_op(4'd2, 16'hFFFF, 16'hFFFF, 1'b0);
    do_op(4'd3, 16'd7, 16'd2, 1'b0);
    do_op(4'd3, 16'd5, 16'd0, 1'b0);
    do_op(4'd1, 16'h0000, 16'h0001, 1'b0);

    // Opcode sweep with random operands; busy start pulse during the mul.
    for (int op = 0; op < 16; op++) begin
      do_op(4'(op), 16'($urandom), 16'($urandom), op == 2);
    end

    // Boundary operands.
    do_op(4'd3, 16'hFFFF, 16'h0001, 1'b0);
    do_op(4'd3, 16'h0000, 16'h0003, 1'b0);
    do_op(4'd3, 16'h0003, 16'hFFFF, 1'b0);
    do_op(4'd2, 16'h0000, 16'h1234, 1'b0);
    do_op(4'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    do_op(4'd12, 16'h8001, 16'h0000, 1'b0);
    do_op(4'd13, 16'h8001, 16'h0000, 1'b0);
    do_op(4'd4, 16'hFFFF, 16'h0000, 1'b0);
    do_op(4'd5, 16'h0000, 16'h0000, 1'b0);

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      do_op(4'($urandom), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'b0);
    end

    // Reset in the middle of a divide.
    do_op(4'd3, 16'd9, 16'd0, 1'b0);
    start_i = 1'b1; a_i = 16'd7; b_i = 16'd2; opcode_i = 4'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst ready", 64'(ready_o), 64'd1);
    chk("midrst done", 64'(done_o), 64'd0);
    chk("midrst out_alu", 64'(out_alu_o), 64'd0);
    chk("midrst flags", 64'(flags_now()), 64'd0);
    chk("midrst dbz", 64'(div_by_zero_o), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_o) dn++;
    end
    chk("midrst no_done", 64'(dn), 64'd0);
    last_exp = '0;
    do_op(4'd0, 16'h0004, 16'h0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width (legal range 4..32).
REQ-002 The block SHALL have parameter FAST_MUL, default 0: 0 = iterative multiply, 1 = single-cycle multiply.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; accepted only when ready=1.
REQ-006 ready  output  1  high when idle and able to accept start.
REQ-007 a  input  WIDTH  operand A, sampled on accept.
REQ-008 b  input  WIDTH  operand B, sampled on accept.
REQ-009 opcode  input  4  operation select; opcode[3]=0 arithmetic, opcode[3]=1 logic; sampled on accept.
REQ-010 out_alu  output  2*WIDTH  registered result, held until the next done.
REQ-011 done  output  1  one-cycle pulse when out_alu and the flags are updated.
REQ-012 z_a_flag, z_b_flag, a_bigger_flag, b_bigger_flag, eq_flag  output  1 each  registered unsigned compare flags of the accepted operands.
REQ-013 div_by_zero  output  1  set with done for division with b=0; cleared on the next accept.

Function
REQ-014 Opcodes SHALL be: 0 add, 1 sub, 2 mul, 3 div, 4 inc a, 5 dec a, 6 pass a, 7 pass b, 8 and, 9 or, 10 xor, 11 not a, 12 shl a by 1, 13 shr a by 1 (logical), 14 nand, 15 nor.
REQ-015 Add SHALL place the sum in out_alu[WIDTH-1:0] and the carry in bit WIDTH; all upper bits SHALL be 0.
REQ-016 Sub SHALL place (a-b) mod 2^WIDTH in the low WIDTH bits and the borrow (a<b) in bit WIDTH; all upper bits SHALL be 0.
REQ-017 Inc and dec SHALL wrap modulo 2^WIDTH with no carry output; upper WIDTH bits SHALL be 0.
REQ-018 Logic, shift and pass results SHALL occupy the low WIDTH bits; upper bits SHALL be 0; shl SHALL discard the MSB.
REQ-019 Mul SHALL be unsigned and produce the full 2*WIDTH-bit product.
REQ-020 Div SHALL be unsigned restoring division with out_alu = {remainder, quotient}.
REQ-021 For div with b=0, out_alu SHALL be all ones, div_by_zero SHALL be 1, and latency SHALL be 1.
REQ-022 FSM states SHALL be IDLE, CALC and DONE.
REQ-023 IDLE with start SHALL go to DONE for single-cycle ops, and to CALC for div with b≠0, or for mul when FAST_MUL=0.
REQ-024 CALC SHALL perform exactly WIDTH iterations and then go to DONE.
REQ-025 DONE SHALL assert done for one cycle and return to IDLE.
REQ-026 Latency, from the accept edge to the done edge, SHALL be 1 cycle for single-cycle ops and WIDTH+1 cycles for iterative ops.
REQ-027 ready SHALL be 1 only in IDLE; start while ready=0 SHALL be ignored and not queued.
REQ-028 Back-to-back throughput SHALL be one accept per 2 cycles minimum, because DONE is a separate cycle.
REQ-029 Flags SHALL be computed from the latched operands and updated on done, not before.
REQ-030 Changes on a, b or opcode after accept SHALL not affect the in-flight operation.

Reset
REQ-031 Asserting rst_n low SHALL, at any time including mid-CALC, asynchronously force IDLE, ready=1, done=0, out_alu=0, all flags=0 and div_by_zero=0.
REQ-032 An interrupted operation SHALL be discarded and SHALL not produce a done after reset release.

Structure
REQ-033 Opcode localparams (ALU_ADD..ALU_NOR) and FSM state encodings SHALL live in shared package alu_pkg.
REQ-034 The iterative shift-add multiply / restoring divide datapath SHALL be one sub-module, alu_muldiv_iter, with start/done and its own iteration counter.
REQ-035 Combinational ops and the flag compare SHALL remain in the top module.

Verification (WIDTH=16, FAST_MUL=0)
REQ-036 a=0x0004, b=0x0001, op=0 -> done 1 cycle after accept, out_alu=0x00000005, a_bigger=1.
REQ-037 a=0xFFFF, b=0xFFFF, op=2 -> ready=0 for 16 cycles, done at cycle 17, out_alu=0xFFFE0001, eq=1.
REQ-038 a=7, b=2, op=3 -> out_alu=0x00010003 after 17 cycles; a=5, b=0, op=3 -> out_alu=0xFFFFFFFF, div_by_zero=1, latency 1.
REQ-039 a=0x0000, b=0x0001, op=1 -> out_alu=0x0001FFFF, z_a=1, b_bigger=1.
REQ-040 Sweep ops 0..15; pulse start again while busy during a mul -> second request ignored and exactly one done observed.
REQ-041 Assert rst_n low at cycle 8 of a div -> all outputs 0 immediately and ready=1; no done follows after release.
